pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central sequencer for the 5-stage RV64 pipeline. Owns the PC and the instruction-fetch handshake.
//  Builds fetch_data_t for the F/D register and generates per-stage stall/flush for F/D, D/E, E/M and M/W.
//  Handles load-use, branch redirect and data-memory wait. Also keeps cycle and instret counters.
//  Sits beside the stage modules in core.sv; has no datapath ALU logic.
// PARAMETERS
//  PC_RESET  64'h8000_0000  PC loaded on reset
//  CNT_W     64             width of the cycle and instret counters
// PORTS
//  clk           in   1        core clock
//  reset         in   1        synchronous, active-high
//  ireq_valid    out  1        ibus request; held until iresp_ok
//  ireq_addr     out  64       ibus address; stable while ireq_valid
//  iresp_ok      in   1        ibus data_ok, one pulse per request
//  iresp_data    in   32       instruction word, valid with iresp_ok
//  fd_o          out  fetch_data_t  F/D pipeline register (valid, raw_instr, pc)
//  d_rs1, d_rs2  in   5        decode source registers
//  d_use1,d_use2 in   1        decode actually reads rs1 / rs2
//  e_valid       in   1        execute stage holds an instruction
//  e_memread     in   1        execute instruction is a load
//  e_dst         in   5        execute destination register
//  e_redirect    in   1        execute resolved a taken branch or jump
//  e_target      in   64       redirect PC
//  m_busy        in   1        memory stage waiting for dbus data_ok
//  w_valid       in   1        writeback retiring a valid instruction
//  stall_d, stall_e, stall_m  out 1  hold that stage's input register
//  flush_e, flush_m, flush_w  out 1  load a bubble (valid=0) into that register
//  cycle_cnt     out  CNT_W    cycles since reset
//  instret_cnt   out  CNT_W    retired instructions
// BEHAVIOUR
//  Reset values
//   pc=PC_RESET; fetch FSM=F_REQ; fd_o='0.
//   All stall and flush outputs 0; both counters 0.
//   ireq_valid=1 from the first cycle after reset.
//  Fetch FSM
//   F_REQ: ireq_valid=1, ireq_addr=pc.
//    On iresp_ok with no redirect and F/D not stalled: fd_o<={1,iresp_data,pc}; pc+=4; stay in F_REQ.
//    On iresp_ok while F/D is stalled: capture into the 1-entry hold buffer, pc+=4 -> F_HOLD.
//   F_HOLD: ireq_valid=0. When the stall clears, fd_o<=buffer -> F_REQ.
//   F_DROP: ireq_valid=1 with the stale addr (bus rule: no withdrawal).
//    On iresp_ok, discard the data -> F_REQ with the new pc.
//   No response pending and F/D not stalled: fd_o.valid<=0 (bubble).
//  Priority each cycle: m_busy > e_redirect > load-use.
//   m_busy
//    stall_d=stall_e=stall_m=1, flush_w=1.
//    fd_o and the hold buffer are frozen; e_redirect is ignored (execute re-presents it).
//   e_redirect (no m_busy)
//    pc<=e_target; fd_o.valid<=0; flush_e=1; hold buffer discarded.
//    FSM: F_REQ with no iresp_ok -> F_DROP. iresp_ok same cycle -> data dropped, F_REQ.
//    FSM: F_HOLD -> F_REQ.
//   load-use
//    Condition: e_valid & e_memread & e_dst!=0 & ((d_use1 & d_rs1==e_dst) | (d_use2 & d_rs2==e_dst)).
//    Action: stall_d=1 (F/D frozen), flush_e=1. Exactly one bubble per load-use hit.
//  flush_m: reserved for exceptions; driven 0.
//  Outputs stall_*/flush_* are combinational from inputs plus FSM state; no extra latency.
//  Counters
//   cycle_cnt +1 every cycle after reset.
//   instret_cnt +1 when w_valid & !flush_w.
//   Both wrap modulo 2^CNT_W.
//  Reset mid-transaction: FSM forced to F_REQ. ibus is reset on the same edge, so no stale response is expected.
// STRUCTURE
//  Package pipes gets:
//   typedef enum fetch_state_t {F_REQ, F_HOLD, F_DROP}
//   parameter PC_RESET
//   struct hazard_ctl_t {stall_d, stall_e, stall_m, flush_e, flush_m, flush_w}
//  Sub-module hazard_unit: purely combinational priority and load-use logic producing hazard_ctl_t.
//  pipe_ctrl keeps the FSM, pc, hold buffer, fd_o register and counters.
// TESTING
//  Reset, iresp_ok every 2nd cycle -> ireq_addr 8000_0000, _0004, _0008; fd_o.valid pulses; instret tracks w_valid.
//  e_redirect to 8000_0100 while F_REQ waits -> F_DROP; next iresp_ok data never appears in fd_o; next ireq_addr=8000_0100.
//  e_memread, e_dst=5, d_rs1=5, d_use1=1 -> one cycle stall_d=1 & flush_e=1. Repeat with e_dst=0 -> no stall.
//  m_busy 3 cycles with e_redirect high -> stall_d/e/m=1 for 3 cycles; redirect taken only once m_busy drops.
//  iresp_ok while stall_d=1 -> F_HOLD, ireq_valid=0; fd_o unchanged until stall clears, then holds the buffered instr.
//  Assert reset while in F_DROP, then run 2^CNT_W wrap with CNT_W=4 -> FSM=F_REQ, pc=PC_RESET; cycle_cnt wraps 15->0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_HOLD = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

  typedef struct packed {
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hazard_ctl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Combinational hazard priority: dbus wait beats redirect beats load-use.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic        m_busy,
  input  logic        e_redirect,
  input  logic        e_valid,
  input  logic        e_memread,
  input  logic [4:0]  e_dst,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_use1,
  input  logic        d_use2,
  output hazard_ctl_t ctl,
  output logic        redir_go
);

  logic load_use;

  // x0 never carries a dependency, so a load to x0 cannot cause a stall
  assign load_use = e_valid & e_memread & (e_dst != 5'd0) &
                    ((d_use1 & (d_rs1 == e_dst)) | (d_use2 & (d_rs2 == e_dst)));

  // Resolve the highest-priority hazard into stall/flush controls
  always_comb begin
    ctl      = '0;
    redir_go = 1'b0;
    if (m_busy) begin
      // whole front end freezes; the redirect is re-presented once memory completes
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.flush_w = 1'b1;
    end else if (e_redirect) begin
      ctl.flush_e = 1'b1;
      redir_go    = 1'b1;
    end else if (load_use) begin
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: PC, ibus fetch handshake, F/D register, hazards, counters.
module pipe_ctrl #(
  parameter logic [63:0] PC_RESET = pipe_ctrl_pkg::PC_RESET,
  parameter int          CNT_W    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      ireq_valid,
  output logic [63:0]               ireq_addr,
  input  logic                      iresp_ok,
  input  logic [31:0]               iresp_data,
  output pipe_ctrl_pkg::fetch_data_t fd_o,
  input  logic [4:0]                d_rs1,
  input  logic [4:0]                d_rs2,
  input  logic                      d_use1,
  input  logic                      d_use2,
  input  logic                      e_valid,
  input  logic                      e_memread,
  input  logic [4:0]                e_dst,
  input  logic                      e_redirect,
  input  logic [63:0]               e_target,
  input  logic                      m_busy,
  input  logic                      w_valid,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      stall_m,
  output logic                      flush_e,
  output logic                      flush_m,
  output logic                      flush_w,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          instret_cnt
);
  import pipe_ctrl_pkg::*;

  fetch_state_t state, state_nxt;
  logic [63:0]  pc, pc_nxt;
  logic [63:0]  drop_addr, drop_nxt;
  fetch_data_t  fd_q, fd_nxt;
  fetch_data_t  hold_q, hold_nxt;
  hazard_ctl_t  hz;
  logic         redir_go;

  hazard_unit u_hazard (
    .m_busy     (m_busy),
    .e_redirect (e_redirect),
    .e_valid    (e_valid),
    .e_memread  (e_memread),
    .e_dst      (e_dst),
    .d_rs1      (d_rs1),
    .d_rs2      (d_rs2),
    .d_use1     (d_use1),
    .d_use2     (d_use2),
    .ctl        (hz),
    .redir_go   (redir_go)
  );

  assign stall_d = hz.stall_d;
  assign stall_e = hz.stall_e;
  assign stall_m = hz.stall_m;
  assign flush_e = hz.flush_e;
  assign flush_m = hz.flush_m;
  assign flush_w = hz.flush_w;

  // A stale request must stay on the bus with its original address until answered
  assign ireq_valid = (state != F_HOLD);
  assign ireq_addr  = (state == F_DROP) ? drop_addr : pc;
  assign fd_o       = fd_q;

  // Fetch next-state, PC, F/D and hold-buffer update
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop_addr;
    fd_nxt    = fd_q;
    hold_nxt  = hold_q;
    unique case (state)
      F_REQ: begin
        if (redir_go) begin
          pc_nxt       = e_target;
          fd_nxt.valid = 1'b0;
          if (!iresp_ok) begin
            state_nxt = F_DROP;
            drop_nxt  = pc;
          end
        end else if (hz.stall_d) begin
          if (iresp_ok) begin
            hold_nxt  = '{valid: 1'b1, raw_instr: iresp_data, pc: pc};
            pc_nxt    = pc + 64'd4;
            state_nxt = F_HOLD;
          end
        end else if (iresp_ok) begin
          fd_nxt = '{valid: 1'b1, raw_instr: iresp_data, pc: pc};
          pc_nxt = pc + 64'd4;
        end else begin
          fd_nxt.valid = 1'b0;
        end
      end
      F_HOLD: begin
        if (redir_go) begin
          // buffered instruction is on the wrong path; just drop it
          pc_nxt       = e_target;
          fd_nxt.valid = 1'b0;
          state_nxt    = F_REQ;
        end else if (!hz.stall_d) begin
          fd_nxt    = hold_q;
          state_nxt = F_REQ;
        end
      end
      F_DROP: begin
        if (redir_go) begin
          pc_nxt       = e_target;
          fd_nxt.valid = 1'b0;
        end else if (!hz.stall_d) begin
          fd_nxt.valid = 1'b0;
        end
        if (iresp_ok) state_nxt = F_REQ;
      end
      default: state_nxt = F_REQ;
    endcase
  end

  // Fetch state, PC and pipeline register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= F_REQ;
      pc        <= PC_RESET;
      drop_addr <= PC_RESET;
      fd_q      <= '0;
      hold_q    <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_nxt;
      fd_q      <= fd_nxt;
      hold_q    <= hold_nxt;
    end
  end

  // Free-running cycle count and retirement count; writeback flush suppresses retirement
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      instret_cnt <= instret_cnt + {{(CNT_W-1){1'b0}}, (w_valid & ~hz.flush_w)};
    end
  end

endmodule
